// File: rtl/piggy_top.sv
// piggy_top: Tiny Tapeout "piggy bank" coin accumulator.
// Coin and smash strobes are synchronised and edge-detected. Accepted coins add
// to a saturating 16-bit balance and bump an 8-bit coin count. Optional macro
// PIGGY_BCD_EN keeps a packed-BCD copy of the balance for the display bytes.
`timescale 1ns/1ps
module piggy_top #(
  parameter int MAX_BALANCE = 9999,
  parameter int DATA_W      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [DATA_W:0]   MAX_EXT  = (DATA_W+1)'(MAX_BALANCE);
  localparam logic [DATA_W-1:0] FULL_THR = DATA_W'(MAX_BALANCE - 25);

  // Binary value of a coin type.
  function automatic logic [4:0] coin_value(input logic [1:0] t);
    logic [4:0] v;
    case (t)
      2'b00:   v = 5'd1;
      2'b01:   v = 5'd5;
      2'b10:   v = 5'd10;
      default: v = 5'd25;
    endcase
    return v;
  endfunction

  // Coin counter holds at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

`ifdef PIGGY_BCD_EN
  // Packed-BCD value of a coin type.
  function automatic logic [7:0] coin_bcd(input logic [1:0] t);
    logic [7:0] v;
    case (t)
      2'b00:   v = 8'h01;
      2'b01:   v = 8'h05;
      2'b10:   v = 8'h10;
      default: v = 8'h25;
    endcase
    return v;
  endfunction

  // Four-digit BCD add; the accept check keeps the result within 9999.
  function automatic logic [15:0] bcd_add(input logic [15:0] a, input logic [7:0] b);
    logic [15:0] r;
    logic [15:0] b16;
    logic [4:0]  d;
    logic        c;
    r   = '0;
    b16 = {8'h00, b};
    c   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[4*i +: 4]} + {1'b0, b16[4*i +: 4]} + {4'b0000, c};
      if (d > 5'd9) begin
        d = d + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i +: 4] = d[3:0];
    end
    return r;
  endfunction
`endif

  logic              coin_p0, coin_p1, coin_p2;
  logic              smash_p0, smash_p1, smash_p2;
  logic              coin_vld_p2, smash_vld_p2;
  logic [DATA_W-1:0] balance;
  logic [7:0]        coin_count;
  logic              reject_sticky;
  logic [DATA_W:0]   sum_ext;
  logic              fits;
  logic              empty, goal_reached, full;
  logic              unused_ok;

  assign unused_ok = &{1'b0, ui_in[7:6], uio_in[7:4]};

  // Stage p0/p1 synchronise the strobes; p2 holds the previous level for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coin_p0  <= 1'b0;
      coin_p1  <= 1'b0;
      coin_p2  <= 1'b0;
      smash_p0 <= 1'b0;
      smash_p1 <= 1'b0;
      smash_p2 <= 1'b0;
    end else begin
      coin_p0  <= ui_in[0];
      coin_p1  <= coin_p0;
      coin_p2  <= coin_p1;
      smash_p0 <= ui_in[3];
      smash_p1 <= smash_p0;
      smash_p2 <= smash_p1;
    end
  end

  assign coin_vld_p2  = coin_p1 & ~coin_p2;
  assign smash_vld_p2 = smash_p1 & ~smash_p2;

  // One bit wider than the balance, so the limit compare can never see a wrap.
  assign sum_ext = {1'b0, balance} + {{(DATA_W-4){1'b0}}, coin_value(ui_in[2:1])};
  assign fits    = (sum_ext <= MAX_EXT);

  // Bank state: smash beats a coin in the same cycle; ena gates all updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      balance       <= '0;
      coin_count    <= '0;
      reject_sticky <= 1'b0;
    end else if (ena) begin
      if (smash_vld_p2) begin
        balance       <= '0;
        coin_count    <= '0;
        reject_sticky <= 1'b0;
      end else if (coin_vld_p2) begin
        if (fits) begin
          balance    <= sum_ext[DATA_W-1:0];
          coin_count <= sat_inc(coin_count);
        end else begin
          reject_sticky <= 1'b1;
        end
      end
    end
  end

`ifdef PIGGY_BCD_EN
  logic [15:0] balance_bcd;

  // Decimal shadow of the balance, following the same accept/reject/smash rules.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      balance_bcd <= '0;
    end else if (ena) begin
      if (smash_vld_p2) begin
        balance_bcd <= '0;
      end else if (coin_vld_p2 && fits) begin
        balance_bcd <= bcd_add(balance_bcd, coin_bcd(ui_in[2:1]));
      end
    end
  end

  // Display byte: count, or a pair of BCD digits.
  always_comb begin
    uo_out = 8'h00;
    if (ui_in[5])      uo_out = coin_count;
    else if (!ui_in[4]) uo_out = balance_bcd[7:0];
    else               uo_out = balance_bcd[15:8];
  end
`else
  // Display byte: count, or one byte of the binary balance.
  always_comb begin
    uo_out = 8'h00;
    if (ui_in[5])      uo_out = coin_count;
    else if (!ui_in[4]) uo_out = balance[7:0];
    else               uo_out = balance[15:8];
  end
`endif

  assign empty        = (balance == '0);
  assign goal_reached = (balance >= {{(DATA_W-12){1'b0}}, uio_in[3:0], 8'h00});
  assign full         = (balance > FULL_THR);

  assign uio_out = {reject_sticky, full, goal_reached, empty, 4'h0};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_piggy_top.sv
// Bench for piggy_top: directed coin/smash sequences; expected display and
// status bytes are queued by the stimulus and compared by a separate monitor.
`timescale 1ns/1ps
module tb_piggy_top;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  typedef struct {
    string      name;
    logic [7:0] uo;
    logic [7:0] uio;
    logic [7:0] oe;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;

  piggy_top dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // Monitor: drains the scoreboard whenever the stimulus publishes an expectation.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (uo_out !== e.uo || uio_out !== e.uio || uio_oe !== e.oe) begin
          errors++;
          $display("FAIL %s: got uo_out=%h uio_out=%h uio_oe=%h, want uo_out=%h uio_out=%h uio_oe=%h",
                   e.name, uo_out, uio_out, uio_oe, e.uo, e.uio, e.oe);
        end
      end
    end
  end

  // Selects the display view, then publishes the expected outputs.
  task automatic expect_out(input string name, input logic cnt_sel, input logic hi_sel,
                            input logic [7:0] uo_e, input logic [7:0] uio_e);
    exp_t e;
    int   guard;
    ui_in[5] = cnt_sel;
    ui_in[4] = hi_sel;
    #1;
    e.name = name;
    e.uo   = uo_e;
    e.uio  = uio_e;
    e.oe   = 8'hF0;
    sb.push_back(e);
    ->chk_ev;
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      #1;
      guard++;
    end
    if (sb.size() != 0) begin
      $display("FAIL %s: monitor did not consume expectation, got pending=%0d want 0", name, sb.size());
      checks++;
      errors++;
      sb.delete();
    end
  endtask

  // One-cycle strobe on the given ui_in bit(s), then let it settle.
  task automatic pulse(input logic coin_b, input logic smash_b, input logic [1:0] t);
    ui_in[2:1] = t;
    ui_in[0]   = coin_b;
    ui_in[3]   = smash_b;
    @(posedge clk);
    #1;
    ui_in[0] = 1'b0;
    ui_in[3] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] t);
    pulse(1'b1, 1'b0, t);
  endtask

  task automatic smash();
    pulse(1'b0, 1'b1, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h01;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_out("reset_lo", 1'b0, 1'b0, 8'h00, 8'h10);
    expect_out("reset_cnt", 1'b1, 1'b0, 8'h00, 8'h10);

    // 25 + 10 + 5 + 1 = 41
    coin(2'b11);
    coin(2'b10);
    coin(2'b01);
    coin(2'b00);
    expect_out("sum41_lo", 1'b0, 1'b0, 8'h29, 8'h00);
    expect_out("sum41_hi", 1'b0, 1'b1, 8'h00, 8'h00);
    expect_out("sum41_cnt", 1'b1, 1'b0, 8'h04, 8'h00);

    smash();
    expect_out("smash_lo", 1'b0, 1'b0, 8'h00, 8'h10);
    expect_out("smash_cnt", 1'b1, 1'b0, 8'h00, 8'h10);

    // Held strobe: one event, visible after the third rising edge.
    ui_in[5:4] = 2'b00;
    ui_in[2:1] = 2'b11;
    ui_in[0]   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_out("hold_edge2", 1'b0, 1'b0, 8'h00, 8'h10);
    @(posedge clk);
    #1;
    expect_out("hold_edge3", 1'b0, 1'b0, 8'h19, 8'h00);
    repeat (17) @(posedge clk);
    #1;
    ui_in[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_out("hold_once_lo", 1'b0, 1'b0, 8'h19, 8'h00);
    expect_out("hold_once_cnt", 1'b1, 1'b0, 8'h01, 8'h00);

    // Fill to 9975 with 398 more 25-coins.
    for (int i = 0; i < 398; i++) coin(2'b11);
    expect_out("fill_lo", 1'b0, 1'b0, 8'hF7, 8'h60);
    expect_out("fill_hi", 1'b0, 1'b1, 8'h26, 8'h60);
    expect_out("fill_cnt_sat", 1'b1, 1'b0, 8'hFF, 8'h60);

    coin(2'b11);
    expect_out("reject_lo", 1'b0, 1'b0, 8'hF7, 8'hE0);
    expect_out("reject_hi", 1'b0, 1'b1, 8'h26, 8'hE0);
    expect_out("reject_cnt", 1'b1, 1'b0, 8'hFF, 8'hE0);

    coin(2'b00);
    expect_out("one_after_full", 1'b0, 1'b0, 8'hF8, 8'hE0);

    // Coin and smash together: smash wins and clears the reject flag.
    pulse(1'b1, 1'b1, 2'b11);
    expect_out("both_lo", 1'b0, 1'b0, 8'h00, 8'h10);
    expect_out("both_cnt", 1'b1, 1'b0, 8'h00, 8'h10);

    // Goal threshold at 256, with ignored pins toggled.
    ui_in[7:6] = 2'b11;
    for (int i = 0; i < 10; i++) coin(2'b11);
    expect_out("goal_250", 1'b0, 1'b0, 8'hFA, 8'h00);
    coin(2'b10);
    expect_out("goal_260_lo", 1'b0, 1'b0, 8'h04, 8'h20);
    expect_out("goal_260_hi", 1'b0, 1'b1, 8'h01, 8'h20);
    uio_in = 8'hF0;
    expect_out("goal_zero", 1'b0, 1'b0, 8'h04, 8'h20);
    uio_in = 8'h02;
    expect_out("goal_512", 1'b0, 1'b0, 8'h04, 8'h00);
    uio_in = 8'h01;

    // Disabled: the event is consumed without effect.
    ena = 1'b0;
    coin(2'b11);
    ena = 1'b1;
    expect_out("ena_off_lo", 1'b0, 1'b0, 8'h04, 8'h20);
    expect_out("ena_off_cnt", 1'b1, 1'b0, 8'h0B, 8'h20);
    repeat (2) @(posedge clk);
    #1;
    expect_out("ena_no_replay", 1'b0, 1'b0, 8'h04, 8'h20);

    // Asynchronous reset mid-count, checked before any rising edge.
    ui_in[2:1] = 2'b01;
    ui_in[0]   = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst_lo", 1'b0, 1'b0, 8'h00, 8'h10);
    expect_out("async_rst_cnt", 1'b1, 1'b0, 8'h00, 8'h10);
    ui_in[0] = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piggy_top.md
Name: piggy_top

Overview:
- Tiny Tapeout top-level "piggy bank" coin accumulator.
- Coin deposits arrive as strobed pin inputs. Each accepted coin adds its value to a saturating balance and increments a coin count.
- A "smash" strobe empties the bank.
- Balance or count is shown on uo_out; status flags are driven on the upper uio pins.

Parameters:
MAX_BALANCE, 9999, highest balance the bank may hold; coins that would exceed it are rejected.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; when 0, strobe edges are ignored and state holds
ui_in  input  8  [0] coin strobe; [2:1] coin type; [3] smash strobe; [4] byte select; [5] show count; [7:6] unused
uo_out  output  8  display byte
uio_in  input  8  [3:0] goal nibble; [7:4] ignored
uio_out  output  8  [3:0]=0; [4] empty; [5] goal_reached; [6] full; [7] reject_sticky
uio_oe  output  8  constant 8'hF0

Behaviour:
- Reset (rst_n=0, asynchronous):
  - balance=0, coin_count=0, reject_sticky=0, synchronizers=0.
  - uo_out=0; uio_out=8'h10 (empty=1); uio_oe=8'hF0 at all times.
- ui_in[0] and ui_in[3] each pass through a 2-FF synchronizer plus a third edge-detect register. An edge is s2 & ~s3.
  - A pin raised before clock edge k updates state at edge k+2; the result is visible after edge k+2.
  - Holding a strobe high yields exactly one event.
- Coin values by ui_in[2:1], sampled in the event cycle without synchronization (held stable by the user): 00→1, 01→5, 10→10, 11→25.
- Coin event with ena=1:
  - If balance+value <= MAX_BALANCE: balance += value, and coin_count += 1, saturating at 255.
  - Otherwise: balance and coin_count unchanged, and reject_sticky set to 1.
- Smash event with ena=1: balance=0, coin_count=0, reject_sticky=0.
- Coin and smash events in the same cycle: smash wins; the coin is discarded and not counted as a reject.
- ena=0: events are consumed (edge registers still advance) but cause no state change.
- Balance is 16-bit unsigned internally; the add is computed at 17 bits, so there is never wrap-around.
- uo_out is combinational from registers:
  - ui_in[5]=1: coin_count.
  - else ui_in[4]=0: balance[7:0].
  - else: balance[15:8].
- Status flags:
  - empty = (balance==0).
  - goal_reached = balance >= uio_in[3:0]*256. Goal 0 means always reached.
  - full = balance > MAX_BALANCE-25, i.e. a 25 coin cannot be accepted.
  - reject_sticky is a register.
- ui_in[7:6] and uio_in[7:4] have no effect.

Optional Feature:
- Macro PIGGY_BCD_EN.
- Defined:
  - A 4-digit packed-BCD balance register is maintained alongside the binary balance, updated with the same accept/reject/smash rules. MAX_BALANCE must be <= 9999.
  - With ui_in[5]=0, uo_out shows BCD: ui_in[4]=0 → {tens,units}; ui_in[4]=1 → {thousands,hundreds}.
  - Flags still use the binary balance.
- Undefined: uo_out shows binary bytes as above; no BCD logic is present.

Test Plan:
- Reset, then release → uo_out=0, uio_out=8'h10, uio_oe=8'hF0.
- Deposit types 11,10,01,00 (one pulse each, ui_in[4]=0) → uo_out=41 (0x29); ui_in[5]=1 → uo_out=4; empty=0.
- Hold coin strobe high for 20 cycles with type 11 → balance increments once, to 25; first change appears exactly 3 rising edges after assertion.
- Deposit 25-coins up to 9975 (399 coins), then one more 25 → balance stays 9975 (0x26F7), uo_out high byte 0x26, full=1, reject_sticky=1, count=255; a 1-coin is still accepted, giving 9976.
- Set uio_in[3:0]=1, deposit 10 ×25 = 250 → goal_reached=0; one more 10 → 260 → goal_reached=1.
- Coin and smash raised in the same cycle → balance=0, count=0, reject_sticky=0. Assert rst_n low mid-count → outputs return to reset values immediately, without a clock edge.
